// File: rtl/rv32i_dmem_if.sv
// Core load/store bus: the core drives the request side (master), the data memory answers (slave).
interface rv32i_dmem_if;
  logic        clkEn;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic        wrEn;
  logic        rdEn;
  logic [3:0]  RamMode;
  logic [31:0] rdData;
  logic        rdDataEn;
  logic        err;

  modport master (
    output clkEn, addr, wrData, wrEn, rdEn, RamMode,
    input  rdData, rdDataEn, err
  );

  modport slave (
    input  clkEn, addr, wrData, wrEn, rdEn, RamMode,
    output rdData, rdDataEn, err
  );
endinterface

// File: rtl/rv32i_dmem.sv
// Windowed RV32I data memory: lane-steered stores, extended loads returned two cycles after the
// request, one request per cycle, one-cycle err pulse for malformed requests inside the window.
module rv32i_dmem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rstB,
  rv32i_dmem_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] WIN_SPAN = 33'(4) * 33'(DEPTH);

  // Request decode (cycle N)
  logic [32:0]   diff;
  logic          hit;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          isByte;
  logic          isHalf;
  logic          isWord;
  logic          isUnsigned;
  logic          modeValid;
  logic          misaligned;
  logic          accepted;
  logic          bad;
  logic          doStore;

  // A 33-bit difference makes addresses below the base wrap to huge values, so one compare
  // covers both ends of the window.
  assign diff = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign hit  = (diff < WIN_SPAN);
  assign idx  = diff[AW+1:2];
  assign off  = bus.addr[1:0];

  always_comb begin
    isByte     = 1'b0;
    isHalf     = 1'b0;
    isWord     = 1'b0;
    isUnsigned = bus.RamMode[0];
    case (bus.RamMode)
      4'b1000, 4'b1001: isByte = 1'b1;
      4'b0100, 4'b0101: isHalf = 1'b1;
      4'b0010:          isWord = 1'b1;
      default:          ;
    endcase
  end

  assign modeValid  = isByte || isHalf || isWord;
  assign misaligned = (isHalf && off[0]) || (isWord && (off != 2'b00));
  assign accepted   = bus.clkEn && (bus.wrEn || bus.rdEn) && hit;
  assign bad        = accepted && (!modeValid || misaligned || (bus.wrEn && bus.rdEn));
  assign doStore    = rstB && accepted && bus.wrEn && !bus.rdEn && !bad;

  // Byte-lane storage: one array per lane so partial stores need no read-modify-write.
  logic [31:0] rdWord;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);

      logic [7:0] mem [DEPTH];
      logic       laneSel;
      logic [7:0] laneData;
      logic [7:0] rdByteReg;

      assign laneSel  = isWord
                     || (isHalf && (off[1] == LANE[1]))
                     || (isByte && (off == LANE));
      // Store data arrives right-aligned, so narrow stores replicate the low byte/half.
      assign laneData = isByte ? bus.wrData[7:0]
                      : isHalf ? bus.wrData[8*(gi%2) +: 8]
                      :          bus.wrData[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (doStore && laneSel) begin
          mem[idx] <= laneData;
        end
      end

      always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
          rdByteReg <= '0;
        end else begin
          rdByteReg <= mem[idx];
        end
      end

      assign rdWord[8*gi +: 8] = rdByteReg;
    end
  endgenerate

  // Stage 1 control (edge ending N)
  logic [1:0] offReg;
  logic       modeByteReg;
  logic       modeHalfReg;
  logic       unsignedReg;
  logic       loadValidReg;
  logic       loadBadReg;
  logic       errReg;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      offReg       <= '0;
      modeByteReg  <= 1'b0;
      modeHalfReg  <= 1'b0;
      unsignedReg  <= 1'b0;
      loadValidReg <= 1'b0;
      loadBadReg   <= 1'b0;
      errReg       <= 1'b0;
    end else begin
      offReg       <= off;
      modeByteReg  <= isByte;
      modeHalfReg  <= isHalf;
      unsignedReg  <= isUnsigned;
      loadValidReg <= accepted && bus.rdEn && !bus.wrEn;
      loadBadReg   <= bad;
      errReg       <= bad;
    end
  end

  // Stage 2 extraction (edge ending N+1)
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadResult;

  always_comb begin
    loadByte = rdWord[{offReg, 3'b000} +: 8];
    loadHalf = offReg[1] ? rdWord[31:16] : rdWord[15:0];
    if (loadBadReg) begin
      loadResult = '0;
    end else if (modeByteReg) begin
      loadResult = unsignedReg ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
    end else if (modeHalfReg) begin
      loadResult = unsignedReg ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
    end else begin
      loadResult = rdWord;
    end
  end

  logic [31:0] rdDataReg;
  logic        rdDataEnReg;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      rdDataReg   <= '0;
      rdDataEnReg <= 1'b0;
    end else begin
      rdDataEnReg <= loadValidReg;
      if (loadValidReg) begin
        rdDataReg <= loadResult;
      end
    end
  end

  assign bus.rdData   = rdDataReg;
  assign bus.rdDataEn = rdDataEnReg;
  assign bus.err      = errReg;
endmodule

// File: tb/tb_rv32i_dmem.sv
// Scoreboard bench for rv32i_dmem: loads push expected data/cycle, err pushes expected pulse cycle.
module tb_rv32i_dmem;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
  localparam logic [3:0]  M_B  = 4'b1000;
  localparam logic [3:0]  M_BU = 4'b1001;
  localparam logic [3:0]  M_H  = 4'b0100;
  localparam logic [3:0]  M_HU = 4'b0101;
  localparam logic [3:0]  M_W  = 4'b0010;

  logic clk  = 1'b0;
  logic rstB = 1'b0;

  rv32i_dmem_if bus();

  rv32i_dmem #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstB (rstB),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       name;
  } load_t;

  load_t       loadQ[$];
  int          errQ[$];
  int          cyc        = 0;
  int          compared   = 0;
  int          mismatched = 0;
  int          rdEnSeen   = 0;
  logic [31:0] model [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: compares every rdDataEn / err event against the scoreboard.
  always @(negedge clk) begin
    if (rstB) begin
      if (bus.rdDataEn) begin
        rdEnSeen++;
        compared++;
        if (loadQ.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_rdDataEn cycle=%0d rdData=%h required no response", cyc, bus.rdData);
        end else begin
          if (loadQ[0].due != cyc) begin
            mismatched++;
            $display("FAIL %s timing: rdDataEn at cycle %0d required cycle %0d", loadQ[0].name, cyc, loadQ[0].due);
          end else if (bus.rdData !== loadQ[0].data) begin
            mismatched++;
            $display("FAIL %s data: got %h required %h", loadQ[0].name, bus.rdData, loadQ[0].data);
          end
          void'(loadQ.pop_front());
        end
      end else if (loadQ.size() != 0 && loadQ[0].due <= cyc) begin
        compared++;
        mismatched++;
        $display("FAIL %s missing: no rdDataEn at cycle %0d required one", loadQ[0].name, cyc);
        void'(loadQ.pop_front());
      end
      if (bus.err || (errQ.size() != 0 && errQ[0] == cyc)) begin
        compared++;
        if (errQ.size() != 0 && errQ[0] == cyc) begin
          if (bus.err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_pulse cycle=%0d got %b required 1", cyc, bus.err);
          end
          void'(errQ.pop_front());
        end else begin
          mismatched++;
          $display("FAIL err_spurious cycle=%0d got %b required 0", cyc, bus.err);
        end
      end
    end
  end

  function automatic void modelStore(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic [5:0]  wi;
    logic [31:0] w;
    wi = 6'((a - BASE) >> 2);
    w  = model[wi];
    case (m)
      M_B, M_BU: w[8*a[1:0] +: 8] = d[7:0];
      M_H, M_HU: w[16*a[1] +: 16] = d[15:0];
      default:   w = d;
    endcase
    model[wi] = w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model[6'((a - BASE) >> 2)];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (m)
      M_B:     return {{24{b[7]}}, b};
      M_BU:    return {24'h0, b};
      M_H:     return {{16{h[15]}}, h};
      M_HU:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic en, input logic we, input logic re, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.clkEn   = en;
    bus.wrEn    = we;
    bus.rdEn    = re;
    bus.RamMode = m;
    bus.addr    = a;
    bus.wrData  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, M_W, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b0, m, a, d);
    modelStore(a, m, d);
  endtask

  task automatic load(input logic [3:0] m, input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, 1'b1, m, a, 32'h0);
    loadQ.push_back('{cyc + 2, exp, name});
  endtask

  // Malformed request: err in N+1; a pure load also returns zero data in N+2.
  task automatic badReq(input logic we, input logic re, input logic [3:0] m, input logic [31:0] a, input string name);
    drive(1'b1, we, re, m, a, 32'hFFFF_FFFF);
    errQ.push_back(cyc + 1);
    if (re && !we) loadQ.push_back('{cyc + 2, 32'h0, name});
  endtask

  task automatic checkNoResponse(input int seenBefore, input string name);
    compared++;
    if (rdEnSeen != seenBefore) begin
      mismatched++;
      $display("FAIL %s: %0d responses seen required 0", name, rdEnSeen - seenBefore);
    end
  endtask

  task automatic test_reset();
    bus.clkEn = 1'b0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
    bus.RamMode = M_W; bus.addr = 32'h0; bus.wrData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    compared += 3;
    if (bus.rdData !== 32'h0)   begin mismatched++; $display("FAIL reset_rdData got %h required 0", bus.rdData); end
    if (bus.rdDataEn !== 1'b0)  begin mismatched++; $display("FAIL reset_rdDataEn got %b required 0", bus.rdDataEn); end
    if (bus.err !== 1'b0)       begin mismatched++; $display("FAIL reset_err got %b required 0", bus.err); end
    @(posedge clk);
    #2 rstB = 1'b1;
  endtask

  task automatic test_word();
    store(M_W, BASE + 8, 32'hDEAD_BEEF);
    load(M_W, BASE + 8, 32'hDEAD_BEEF, "lw_deadbeef");
    idle(4);
  endtask

  task automatic test_byte_lanes();
    store(M_W, BASE + 8, 32'h1122_3344);
    store(M_B, BASE + 9, 32'hAABB_CC80);
    load(M_B,  BASE + 9, 32'hFFFF_FF80, "lb_sign");
    load(M_BU, BASE + 9, 32'h0000_0080, "lbu_zero");
    load(M_W,  BASE + 8, 32'h1122_8044, "lw_after_sb");
    idle(4);
  endtask

  task automatic test_back_to_back();
    store(M_H, BASE + 6, 32'h1234_8001);
    load(M_H,  BASE + 6, 32'hFFFF_8001, "lh_sign");
    load(M_HU, BASE + 6, 32'h0000_8001, "lhu_zero");
    idle(4);
  endtask

  task automatic test_raw();
    store(M_W, BASE + 0, 32'hA5A5_A5A5);
    load(M_W,  BASE + 0, 32'hA5A5_A5A5, "lw_raw");
    idle(4);
  endtask

  task automatic test_errors();
    int seen;
    badReq(1'b0, 1'b1, M_W, BASE + 2, "lw_misaligned");
    badReq(1'b1, 1'b0, M_W, BASE + 1, "sw_misaligned");
    badReq(1'b1, 1'b1, M_W, BASE + 0, "both_enables");
    badReq(1'b0, 1'b1, 4'b0011, BASE + 0, "lw_unsigned_invalid");
    badReq(1'b1, 1'b0, M_H, BASE + 1, "sh_misaligned");
    load(M_W, BASE + 0, 32'hA5A5_A5A5, "lw_unchanged_after_bad");
    idle(4);
    seen = rdEnSeen;
    drive(1'b1, 1'b0, 1'b1, M_W, BASE + 32'(4 * DEPTH), 32'h0);
    drive(1'b1, 1'b0, 1'b1, M_W, BASE - 4, 32'h0);
    drive(1'b1, 1'b0, 1'b1, M_W, BASE + 32'(4 * DEPTH) + 2, 32'h0);
    idle(4);
    checkNoResponse(seen, "miss_load");
  endtask

  task automatic test_random_b2b();
    logic [3:0]  modes [5] = '{M_B, M_BU, M_H, M_HU, M_W};
    logic [3:0]  m;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) store(M_W, BASE + 32'(4 * (32 + i)), $urandom());
    for (int i = 0; i < 32; i++) begin
      m = modes[$urandom_range(0, 4)];
      a = BASE + 32'(4 * (32 + $urandom_range(0, 7)));
      if (m == M_B || m == M_BU)      a = a + 32'($urandom_range(0, 3));
      else if (m == M_H || m == M_HU) a = a + 32'(2 * $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) store(m, a, $urandom());
      else                           load(m, a, modelLoad(a, m), "rand_load");
    end
    idle(4);
  endtask

  task automatic test_clken();
    int seen;
    store(M_W, BASE + 12, 32'h0BAD_F00D);
    seen = rdEnSeen;
    drive(1'b0, 1'b0, 1'b1, M_W, BASE + 12, 32'h0);
    drive(1'b0, 1'b1, 1'b0, M_W, BASE + 12, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b1, M_W, BASE + 2, 32'h0);
    idle(4);
    checkNoResponse(seen, "clkEn0_load");
    // A load in flight keeps advancing while clkEn is low behind it.
    load(M_W, BASE + 12, 32'h0BAD_F00D, "lw_clkEn0_store_blocked");
    drive(1'b0, 1'b0, 1'b1, M_W, BASE + 8, 32'h0);
    idle(4);
  endtask

  task automatic test_reset_mid();
    int seen;
    drive(1'b1, 1'b0, 1'b1, M_W, BASE + 8, 32'h0);
    @(posedge clk);
    #1;
    bus.clkEn = 1'b0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
    #2 rstB = 1'b0;
    #1;
    compared += 2;
    if (bus.rdData !== 32'h0)  begin mismatched++; $display("FAIL midreset_rdData got %h required 0", bus.rdData); end
    if (bus.rdDataEn !== 1'b0) begin mismatched++; $display("FAIL midreset_rdDataEn got %b required 0", bus.rdDataEn); end
    @(posedge clk);
    @(posedge clk);
    #2 rstB = 1'b1;
    seen = rdEnSeen;
    idle(5);
    checkNoResponse(seen, "dropped_load_after_reset");
    compared++;
    if (bus.rdData !== 32'h0) begin mismatched++; $display("FAIL postreset_rdData got %h required 0", bus.rdData); end
  endtask

  task automatic test_drain();
    idle(6);
    compared++;
    if (loadQ.size() != 0 || errQ.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d loads %0d errs outstanding required 0", loadQ.size(), errQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_back_to_back();
    test_raw();
    test_errors();
    test_random_b2b();
    test_clken();
    test_drain();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
